pc_gen_unit: RTL
================

Name: pc_gen_unit

Overview:
- Parametrised successor to the single-cycle PC register.
- Generates the fetch PC with a ready/valid fetch handshake, prioritised redirects (exception, eret, jumps, encoded branches) and a pending-redirect buffer so redirects raised during fetch stalls are not lost.
- Keeps an EPC register for exception return.
- Sits between control/ALU flags and instruction memory.

Parameters:
- ADDR_W, 32: PC width; must be at least 30.
- RESET_VEC, 32'h0000_3000: PC after reset.
- EXC_VEC, 32'h0000_4180: exception entry address.
- JUMP_BASE, 32'h0000_3000: offset added to absolute j/jal and jr/jalr targets.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- if_ready  in  1  fetch accepts pc this cycle
- ctrl_valid  in  1  redirect inputs below are meaningful
- br_cond  in  3  000 none, 001 EQ, 010 NE, 011 GEZ, 100 GTZ, 101 LEZ, 110 LTZ
- zero  in  1  compare result equal/zero
- sml  in  1  compare result less-than
- imm16  in  16  branch offset in words, sign-extended
- jmp  in  2  00 none, 01 j/jal, 10 jr/jalr, 11 reserved (treated as none)
- target  in  26  jump index
- jump_reg  in  ADDR_W  register jump source
- exc_req  in  1  take exception
- eret  in  1  return to epc
- pc_valid  out  1  pc is a valid fetch address
- pc  out  ADDR_W  current fetch PC
- pc_plus4  out  ADDR_W  pc + 4, modulo 2^ADDR_W (link value)
- redirect  out  1  one-cycle pulse when pc is loaded from a non-sequential source
- epc  out  ADDR_W  saved exception PC

Behaviour:
- Reset, when rst = 0 at a posedge:
  - pc = RESET_VEC, pc_valid = 0, redirect = 0, epc = 0.
  - Pending buffer cleared; state = BOOT.
  - Reset mid-HOLD discards the pending redirect.
- States:
  - BOOT: next edge sets pc_valid = 1 and goes to RUN; pc does not advance.
  - RUN: normal operation.
  - HOLD: a redirect is buffered while if_ready = 0.
- Next-address candidates, highest priority first, sampled only when ctrl_valid = 1:
  - exc_req: EXC_VEC; also epc <= pc on the same edge.
  - eret: epc.
  - jmp = 01: {pc[ADDR_W-1:28], target, 2'b00} + JUMP_BASE.
  - jmp = 10: jump_reg + JUMP_BASE.
  - Branch taken: pc + (sext(imm16) << 2).
  - Otherwise: pc_plus4.
- Branch taken conditions:
  - EQ: zero. NE: ~zero.
  - GEZ: ~sml | zero. GTZ: ~sml & ~zero.
  - LEZ: sml | zero. LTZ: sml.
- All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- RUN, if_ready = 1: pc <= selected candidate. redirect = 1 on the next cycle iff the candidate was non-sequential.
- RUN, if_ready = 0:
  - pc holds.
  - A non-sequential candidate is stored in pend_addr and the state moves to HOLD.
  - A sequential candidate is dropped.
- HOLD, if_ready = 0: pc holds. A new candidate overwrites pend_addr, except that a buffered exception is only overwritten by another exception.
- HOLD, if_ready = 1:
  - A new exc_req in the same cycle wins over the buffer.
  - Otherwise pc <= pend_addr, redirect pulses, state returns to RUN.
  - Other same-cycle requests are ignored; control is flushed by redirect.
- exc_req and eret in the same cycle: exception wins; epc is overwritten.
- pc_valid stays 1 except during reset and BOOT.

Optional Feature:
- Macro PC_MISALIGN_EN.
- Defined:
  - A jr/jalr or eret target with addr[1:0] != 0 is replaced by EXC_VEC.
  - epc <= pc on that edge.
  - Added output bad_addr (ADDR_W, reset 0) captures the offending target.
  - The exception-priority rules apply to the converted request.
- Undefined: targets are used as computed, with low bits untouched, and bad_addr does not exist.

Decomposition:
- Package pc_gen_pkg:
  - br_cond encodings (BR_NONE..BR_LTZ).
  - jmp encodings.
  - State enum (BOOT, RUN, HOLD).
- Sub-module pc_next_sel: purely combinational candidate computation, condition evaluation and priority mux.
- The top level holds the pc, pending buffer, epc and FSM.

Test Plan:
- Reset release with if_ready = 1 and no requests -> pc = 0x3000, pc_valid = 0 for 1 cycle, then pc = 0x3000, 0x3004, 0x3008.
- pc = 0x3010, br_cond = NE, zero = 0, imm16 = 0xFFFC -> pc = 0x3000, redirect pulses for 1 cycle; the same with zero = 1 -> pc = 0x3014.
- jmp = 01, target = 0x000_0010 -> pc = 0x3040; jmp = 10, jump_reg = 0x20 -> pc = 0x3020.
- if_ready = 0 and a jr to 0x3100 in the same cycle, stall held 3 cycles with a later branch request -> pc holds; when if_ready rises, pc = the later branch target.
- Stalled with a buffered exception, then a jump request -> on ready, pc = 0x4180 and epc = the pc at exception time; a following eret -> pc = epc.
- With PC_MISALIGN_EN: jr to jump_reg = 0x2 -> pc = 0x4180, bad_addr = 0x3002.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared encodings for the PC generator: branch conditions, jump kinds, FSM states.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_EQ, BR_NE, BR_GEZ, BR_GTZ, BR_LEZ, BR_LTZ
  } br_cond_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0, JMP_J, JMP_JR, JMP_RSVD
  } jmp_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0, RUN, HOLD
  } state_e;

  function automatic logic br_taken(input logic [2:0] cond, input logic zero, input logic sml);
    case (cond)
      BR_EQ:   return zero;
      BR_NE:   return ~zero;
      BR_GEZ:  return ~sml | zero;
      BR_GTZ:  return ~sml & ~zero;
      BR_LEZ:  return sml | zero;
      BR_LTZ:  return sml;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_gen_unit_next_sel.sv
// Combinational next-PC candidate selection with exception > eret > jump > branch priority.
// PC_MISALIGN_EN turns misaligned jr/eret targets into exceptions.
module pc_next_sel import pc_gen_pkg::*; #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 'h4180,
  parameter logic [ADDR_W-1:0] JUMP_BASE = 'h3000
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [ADDR_W-1:0] epc,
  input  logic              ctrl_valid,
  input  logic [2:0]        br_cond,
  input  logic              zero,
  input  logic              sml,
  input  logic [15:0]       imm16,
  input  logic [1:0]        jmp,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] jump_reg,
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] next_addr,
  output logic              nonseq,
  output logic              is_exc
`ifdef PC_MISALIGN_EN
  ,
  output logic              bad,
  output logic [ADDR_W-1:0] bad_tgt
`endif
);

  logic [ADDR_W-1:0] j_addr, jr_addr, br_addr, tgt;
  logic              raw_exc;

  assign j_addr  = {pc[ADDR_W-1:28], target, 2'b00} + JUMP_BASE;
  assign jr_addr = jump_reg + JUMP_BASE;
  assign br_addr = pc + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    tgt     = pc_plus4;
    nonseq  = 1'b0;
    raw_exc = 1'b0;
    if (ctrl_valid) begin
      if (exc_req) begin
        tgt = EXC_VEC; nonseq = 1'b1; raw_exc = 1'b1;
      end else if (eret) begin
        tgt = epc; nonseq = 1'b1;
      end else if (jmp == JMP_J) begin
        tgt = j_addr; nonseq = 1'b1;
      end else if (jmp == JMP_JR) begin
        tgt = jr_addr; nonseq = 1'b1;
      end else if (br_taken(br_cond, zero, sml)) begin
        tgt = br_addr; nonseq = 1'b1;
      end
    end
  end

`ifdef PC_MISALIGN_EN
  // Only register-sourced targets (eret, jr) can be misaligned.
  logic chk;
  assign chk       = ctrl_valid & ~exc_req & (eret | (jmp == JMP_JR));
  assign bad       = chk & (tgt[1:0] != 2'b00);
  assign bad_tgt   = tgt;
  assign next_addr = bad ? EXC_VEC : tgt;
  assign is_exc    = raw_exc | bad;
`else
  assign next_addr = tgt;
  assign is_exc    = raw_exc;
`endif

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: PC/EPC registers, BOOT/RUN/HOLD FSM and pending-redirect buffer.
// Optional macro PC_MISALIGN_EN adds misaligned-target trapping and the bad_addr output.
module pc_gen_unit import pc_gen_pkg::*; #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 'h3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 'h4180,
  parameter logic [ADDR_W-1:0] JUMP_BASE = 'h3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ready,
  input  logic              ctrl_valid,
  input  logic [2:0]        br_cond,
  input  logic              zero,
  input  logic              sml,
  input  logic [15:0]       imm16,
  input  logic [1:0]        jmp,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] jump_reg,
  input  logic              exc_req,
  input  logic              eret,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic [ADDR_W-1:0] epc
`ifdef PC_MISALIGN_EN
  ,
  output logic [ADDR_W-1:0] bad_addr
`endif
);

  state_e            state;
  logic [ADDR_W-1:0] pend_addr, next_addr;
  logic              pend_exc, nonseq, is_exc;
`ifdef PC_MISALIGN_EN
  logic              bad;
  logic [ADDR_W-1:0] bad_tgt;
`endif

  assign pc_plus4 = pc + ADDR_W'(4);

  pc_next_sel #(.ADDR_W(ADDR_W), .EXC_VEC(EXC_VEC), .JUMP_BASE(JUMP_BASE)) u_sel (
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .ctrl_valid(ctrl_valid),
    .br_cond(br_cond), .zero(zero), .sml(sml), .imm16(imm16), .jmp(jmp),
    .target(target), .jump_reg(jump_reg), .exc_req(exc_req), .eret(eret),
    .next_addr(next_addr), .nonseq(nonseq), .is_exc(is_exc)
`ifdef PC_MISALIGN_EN
    , .bad(bad), .bad_tgt(bad_tgt)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= BOOT;
      pc        <= RESET_VEC;
      pc_valid  <= 1'b0;
      redirect  <= 1'b0;
      epc       <= '0;
      pend_addr <= '0;
      pend_exc  <= 1'b0;
`ifdef PC_MISALIGN_EN
      bad_addr  <= '0;
`endif
    end else begin
      redirect <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (if_ready) begin
            pc       <= next_addr;
            redirect <= nonseq;
          end else if (nonseq) begin
            pend_addr <= next_addr;
            pend_exc  <= is_exc;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // A fresh exception beats whatever is buffered; other requests are flushed.
          if (if_ready) begin
            pc       <= is_exc ? next_addr : pend_addr;
            redirect <= 1'b1;
            pend_exc <= 1'b0;
            state    <= RUN;
          end else if (nonseq && (is_exc || !pend_exc)) begin
            pend_addr <= next_addr;
            pend_exc  <= is_exc;
          end
        end
        default: state <= BOOT;
      endcase
      if (state != BOOT && is_exc) begin
        epc <= pc;
`ifdef PC_MISALIGN_EN
        if (bad) bad_addr <= bad_tgt;
`endif
      end
    end
  end

endmodule
